// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the eight-digit multiplexed seven-segment driver:
//   - NUM_DIGITS / LAST_DIGIT : scan length and the wrap index
//   - SEG7_OFF               : all-off pattern for active-low outputs
//   - digit_idx_t            : 3-bit digit index type
//   - scan_state_t           : BLANK / SHOW scan states
//   - HEX_SEG_TABLE          : hex nibble -> active-low segments g..a
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG7_OFF = 8'hFF;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex digit to seven-segment decoder, active-low, dp excluded.
// Ports:
//   hex    in  4  nibble to display (0..F)
//   seg_n  out 7  segment drive, seg_n[0]=a .. seg_n[6]=g, 0 = lit
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Eight-digit multiplexed seven-segment driver for common-anode displays.
// The divider's scan clock is sampled as data, synchronised into clk_50MHz
// and each rising edge advances one digit. Every digit change is preceded by
// an all-off blank window of BLANK_CYCLES clocks to stop ghosting, and the
// displayed data is latched once per frame when the scan wraps to digit 0.
//
// Parameters:
//   BLANK_CYCLES  blank window length in clk_50MHz cycles, 0..2499
//
// Ports:
//   clk_50MHz   in   1  system clock
//   rst_n       in   1  asynchronous reset, active-low
//   scan_clk    in   1  10 kHz scan clock, asynchronous, treated as data
//   disp_data   in  32  eight hex nibbles, nibble i shown on digit i
//   dp_in       in   8  decimal point per digit, 1 = lit
//   disp_en     in   1  1 = display on, 0 = outputs held off
//   digit_sel   out  8  active-low digit enables, bit i = digit i
//   seg         out  8  active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   frame_done  out  1  one-cycle pulse when digit 0 starts a new frame
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, digits 1..7 whose nibble and
//                               all higher nibbles are zero show no segments
//                               (the decimal point is still driven).
// ---------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_in,
  input  logic        disp_en,
  output logic [7:0]  digit_sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int              CNT_W      = 12;
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  logic scan_sync1;
  logic scan_sync2;
  logic scan_edge_q;
  logic scan_tick;

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic [CNT_W-1:0]  blank_cnt;
  logic [CNT_W-1:0]  blank_cnt_nxt;
  digit_idx_t        digit_idx;
  digit_idx_t        idx_nxt;
  logic [31:0]       shadow_data;
  logic [31:0]       shadow_data_nxt;
  logic [7:0]        shadow_dp;
  logic [7:0]        shadow_dp_nxt;
  logic              wrap;

  logic [3:0]        show_nibble;
  logic [6:0]        dec_seg;
  logic [6:0]        show_seg_low;

  // Two-flop synchroniser on the scan clock, then an edge register. The
  // tick itself is registered so it is a clean one-cycle pulse arriving
  // three clocks after the scan clock rises.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync1  <= 1'b0;
      scan_sync2  <= 1'b0;
      scan_edge_q <= 1'b0;
      scan_tick   <= 1'b0;
    end else begin
      scan_sync1  <= scan_clk;
      scan_sync2  <= scan_sync1;
      scan_edge_q <= scan_sync2;
      scan_tick   <= scan_sync2 & ~scan_edge_q;
    end
  end

  // Scan state register: FSM state, blank counter, current digit and the
  // per-frame shadow copy of the display data. Reset parks the index on the
  // last digit so the first tick wraps to digit 0 and latches a frame.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      blank_cnt   <= '0;
      digit_idx   <= LAST_DIGIT;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      state       <= state_nxt;
      blank_cnt   <= blank_cnt_nxt;
      digit_idx   <= idx_nxt;
      shadow_data <= shadow_data_nxt;
      shadow_dp   <= shadow_dp_nxt;
    end
  end

  // Next-state logic. A tick always wins and restarts the blank window with
  // the new digit. BLANK leaves on the cycle its counter steps from 1 to 0,
  // so the all-off window lasts exactly BLANK_CYCLES clocks. A counter that
  // is already 0 in BLANK only happens after reset and keeps the display
  // dark until the first tick.
  always_comb begin
    state_nxt       = state;
    blank_cnt_nxt   = blank_cnt;
    idx_nxt         = digit_idx;
    shadow_data_nxt = shadow_data;
    shadow_dp_nxt   = shadow_dp;
    wrap            = 1'b0;

    if (scan_tick) begin
      wrap          = (digit_idx == LAST_DIGIT);
      blank_cnt_nxt = BLANK_LOAD;
      state_nxt     = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      if (wrap) begin
        idx_nxt         = '0;
        shadow_data_nxt = disp_data;
        shadow_dp_nxt   = dp_in;
      end else begin
        idx_nxt = digit_idx + 3'd1;
      end
    end else begin
      case (state)
        ST_BLANK: begin
          if (blank_cnt != '0) begin
            blank_cnt_nxt = blank_cnt - 1'b1;
            if (blank_cnt == CNT_W'(1)) begin
              state_nxt = ST_SHOW;
            end
          end
        end
        ST_SHOW: begin
          state_nxt = ST_SHOW;
        end
        default: begin
          state_nxt = ST_BLANK;
        end
      endcase
    end
  end

  // The output stage is registered, so decode is done on the next-state
  // index and shadow data to keep the outputs aligned with the state.
  assign show_nibble = shadow_data_nxt[{idx_nxt, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (show_nibble),
    .seg_n (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  assign upper_zero   = (idx_nxt != '0) &&
                        ((shadow_data_nxt >> {idx_nxt, 2'b00}) == 32'h0);
  assign show_seg_low = upper_zero ? 7'h7F : dec_seg;
`else
  assign show_seg_low = dec_seg;
`endif

  // Registered outputs. disp_en only gates this stage, so scanning, frame
  // latching and frame_done keep running while the display is dark.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel  <= SEG7_OFF;
      seg        <= SEG7_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if ((state_nxt == ST_SHOW) && disp_en) begin
        digit_sel <= ~(8'h01 << idx_nxt);
        seg       <= {~shadow_dp_nxt[idx_nxt], show_seg_low};
      end else begin
        digit_sel <= SEG7_OFF;
        seg       <= SEG7_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver. Each scan-clock edge advances a
// small reference model (digit counter plus a per-frame copy of the data);
// the expected digit/segment pattern is queued and a monitor compares it
// when the driver starts showing a digit, along with the blank window length
// and frame_done pulses. Honours SEG7_LEADING_ZERO_BLANK_EN like the design.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int BLANK_CYCLES = 50;

  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
    bit         check_blank;
  } expect_t;

  expect_t exp_q[$];

  logic        clk_50MHz = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic [31:0] disp_data;
  logic [7:0]  dp_in;
  logic        disp_en;
  logic [7:0]  digit_sel;
  logic [7:0]  seg;
  logic        frame_done;

  int check_count = 0;
  int pass_count  = 0;

  int          model_idx;
  logic [31:0] model_data;
  logic [7:0]  model_dp;
  bit          last_en;
  int          model_wraps;

  int ff_run      = 0;
  int fd_run      = 0;
  int seen_pulses = 0;
  bit prev_off    = 1'b1;

  seg7_scan_driver #(
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .disp_data  (disp_data),
    .dp_in      (dp_in),
    .disp_en    (disp_en),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  // 50 MHz system clock
  always #10 clk_50MHz = ~clk_50MHz;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // What the current model digit should look like on the display
  function automatic expect_t model_expect(bit check_blank);
    expect_t     r;
    logic [31:0] upper;
    logic [3:0]  nib;
    logic [6:0]  low;
    upper = model_data >> (4 * model_idx);
    nib   = upper[3:0];
    low   = SEG_PATTERN[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (model_idx != 0 && upper == 32'h0) low = 7'h7F;
`endif
    r.sel         = ~(8'h01 << model_idx);
    r.seg         = {~model_dp[model_idx], low};
    r.check_blank = check_blank;
    return r;
  endfunction

  // Advance the model by one scan step; a wrap latches the live inputs
  task automatic model_step();
    model_idx = (model_idx + 1) % 8;
    if (model_idx == 0) begin
      model_data = disp_data;
      model_dp   = dp_in;
      model_wraps++;
    end
  endtask

  // One scan-clock period. Input changes are applied 20 clocks after the
  // rising edge, which is inside the blank window of the new digit.
  task automatic applyStimulus(input logic [31:0] next_data,
                               input logic [7:0] next_dp, input logic next_en);
    int high_cycles;
    int low_cycles;
    expect_t e;
    high_cycles = $urandom_range(60, 100);
    low_cycles  = $urandom_range(60, 100);
    @(posedge clk_50MHz);
    #($urandom_range(1, 19));
    scan_clk = 1'b1;
    model_step();
    repeat (20) @(posedge clk_50MHz);
    #2;
    disp_data = next_data;
    dp_in     = next_dp;
    disp_en   = next_en;
    if (next_en) begin
      e = model_expect(last_en);
      exp_q.push_back(e);
    end
    last_en = next_en;
    repeat (high_cycles - 20) @(posedge clk_50MHz);
    #3;
    scan_clk = 1'b0;
    repeat (low_cycles) @(posedge clk_50MHz);
  endtask

  // Scan edge followed by a reset pulse while the new digit is still blank
  task automatic resetMidBlank();
    @(posedge clk_50MHz);
    #5;
    scan_clk = 1'b1;
    model_step();
    repeat (10) @(posedge clk_50MHz);
    #7;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_digit_sel", digit_sel, 8'hFF);
    checkOutput("async_reset_seg", seg, 8'hFF);
    checkOutput("async_reset_frame_done", frame_done, 1'b0);
    exp_q.delete();
    model_idx  = 7;
    model_data = '0;
    model_dp   = '0;
    last_en    = 1'b0;
    scan_clk   = 1'b0;
    repeat (5) @(posedge clk_50MHz);
    #4;
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50MHz);
    checkOutput("post_reset_idle_digit_sel", digit_sel, 8'hFF);
  endtask

  // Monitor: measures blank runs and frame_done widths, and pops the
  // scoreboard whenever a digit starts being shown.
  always @(negedge clk_50MHz) begin : monitor
    expect_t e;
    bit      now_off;
    if (rst_n !== 1'b1) begin
      ff_run   = 0;
      fd_run   = 0;
      prev_off = 1'b1;
    end else begin
      if (frame_done) begin
        fd_run++;
      end else if (fd_run != 0) begin
        checkOutput("frame_done_width", fd_run, 1);
        seen_pulses++;
        fd_run = 0;
      end
      now_off = (digit_sel == 8'hFF) && (seg == 8'hFF);
      if (now_off) begin
        ff_run++;
      end else begin
        if (prev_off) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_show_digit_sel", digit_sel, 8'hFF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("show_digit_sel", digit_sel, e.sel);
            checkOutput("show_seg", seg, e.seg);
            if (e.check_blank) checkOutput("blank_length", ff_run, BLANK_CYCLES);
          end
        end
        ff_run = 0;
      end
      prev_off = now_off;
    end
  end

  // Hard stop in case the design never responds
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d of %0d checks passed",
             pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  p;
    logic        e;

    rst_n       = 1'b0;
    scan_clk    = 1'b0;
    disp_data   = 32'h0123_4567;
    dp_in       = 8'h00;
    disp_en     = 1'b1;
    model_idx   = 7;
    model_data  = '0;
    model_dp    = '0;
    last_en     = 1'b0;
    model_wraps = 0;

    repeat (5) @(negedge clk_50MHz);
    checkOutput("reset_digit_sel", digit_sel, 8'hFF);
    checkOutput("reset_seg", seg, 8'hFF);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50MHz);
    checkOutput("idle_digit_sel", digit_sel, 8'hFF);
    checkOutput("idle_seg", seg, 8'hFF);

    // Four directed frames: digit sweep, mid-frame data change, dp and
    // disp_en handling, then a frame with leading zeros.
    for (int t = 0; t < 32; t++) begin
      d = disp_data;
      p = dp_in;
      e = 1'b1;
      case (t)
        3:          d = 32'hFFFF_FFFF;
        8:          begin d = 32'h0123_4567; p = 8'h01; end
        16:         begin d = 32'h0000_00A5; p = 8'h00; end
        18, 19, 20: e = 1'b0;
        default:    ;
      endcase
      applyStimulus(d, p, e);
    end

    resetMidBlank();

    // Randomised frames, some with leading zeros, some with display off
    for (int t = 0; t < 24; t++) begin
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 7));
      p = 8'($urandom);
      e = ($urandom_range(0, 4) != 0);
      applyStimulus(d, p, e);
    end
    applyStimulus(disp_data, dp_in, 1'b1);

    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(posedge clk_50MHz);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk_50MHz);
    checkOutput("frame_done_count", seen_pulses, model_wraps);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
